// File: rtl/ddr_a2m_cmd_split_pkg.sv
// Shared AXI parameters for the AXI-to-MBA command splitter: beat-size codes,
// FSM state encoding and the per-command byte-count helper.
package ddr_a2m_cmd_split_pkg;

  localparam logic [2:0] P_ASIZE_1  = 3'd0;
  localparam logic [2:0] P_ASIZE_2  = 3'd1;
  localparam logic [2:0] P_ASIZE_4  = 3'd2;
  localparam logic [2:0] P_ASIZE_8  = 3'd3;
  localparam logic [2:0] P_ASIZE_16 = 3'd4;

  localparam int P_TOTAL_W = 13;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } state_e;

  // Bytes in the next command: what is left, clipped at the chunk boundary.
  function automatic logic [8:0] chunk_bytes(input logic [12:0] rem,
                                             input logic [8:0]  space);
    if (rem < {4'd0, space}) begin
      return rem[8:0];
    end else begin
      return space;
    end
  endfunction

endpackage

// File: rtl/ddr_a2m_cmd_split_if.sv
// AXI address channel in, MBA command channel out, plus the illegal-size flag.
interface ddr_a2m_cmd_split_if;
  logic        AXVALID;
  logic        AXREADY;
  logic [31:0] AXADDR;
  logic [7:0]  AXLEN;
  logic [2:0]  AXSIZE;
  logic [3:0]  AXID;
  logic        MVALID;
  logic        MREADY;
  logic [31:0] MADDR;
  logic [8:0]  MBYTES;
  logic [3:0]  MID;
  logic        MLAST;
  logic        ERR;

  modport slave (
    input  AXVALID, AXADDR, AXLEN, AXSIZE, AXID, MREADY,
    output AXREADY, MVALID, MADDR, MBYTES, MID, MLAST, ERR
  );

  modport master (
    output AXVALID, AXADDR, AXLEN, AXSIZE, AXID, MREADY,
    input  AXREADY, MVALID, MADDR, MBYTES, MID, MLAST, ERR
  );
endinterface

// File: rtl/ddr_a2m_cmd_split_total.sv
// AXI total transfer size: (AXLEN+1) << AXSIZE for sizes up to 16 bytes,
// zero for any wider beat code so the caller can flag it.
module ddr_a2m_cmd_split_total
  import ddr_a2m_cmd_split_pkg::*;
(
  input  logic [7:0]           len_i,
  input  logic [2:0]           size_i,
  output logic [P_TOTAL_W-1:0] total_o
);

  logic [P_TOTAL_W-1:0] beats_s;

  assign beats_s = {5'd0, len_i} + 13'd1;

  // Scale the beat count by the beat size.
  always_comb begin
    total_o = 13'd0;
    case (size_i)
      P_ASIZE_1:  total_o = beats_s;
      P_ASIZE_2:  total_o = beats_s << 1;
      P_ASIZE_4:  total_o = beats_s << 2;
      P_ASIZE_8:  total_o = beats_s << 3;
      P_ASIZE_16: total_o = beats_s << 4;
      default:    total_o = 13'd0;
    endcase
  end

endmodule

// File: rtl/ddr_a2m_cmd_split.sv
// Splits one AXI INCR address command into MBA commands that never cross a
// P_CHUNK-byte boundary; one burst in flight, no AXI accept while splitting.
module ddr_a2m_cmd_split
  import ddr_a2m_cmd_split_pkg::*;
#(
  parameter int P_CHUNK = 64
) (
  input logic                CLK,
  input logic                RST_N,
  ddr_a2m_cmd_split_if.slave bus
);

  localparam int OFS_W = $clog2(P_CHUNK);

  state_e                state_q;
  logic [31:0]           addr_q;
  logic [P_TOTAL_W-1:0]  rem_q;
  logic [3:0]            id_q;
  logic                  axready_q;
  logic                  mvalid_q;
  logic                  err_q;

  logic [P_TOTAL_W-1:0]  total_s;
  logic [OFS_W-1:0]      ofs_s;
  logic [8:0]            space_s;
  logic [8:0]            mbytes_s;
  logic                  mlast_s;
  logic                  ax_fire_s;
  logic                  m_fire_s;

  ddr_a2m_cmd_split_total u_total (
    .len_i   (bus.AXLEN),
    .size_i  (bus.AXSIZE),
    .total_o (total_s)
  );

  assign ofs_s     = addr_q[OFS_W-1:0];
  assign space_s   = 9'(P_CHUNK) - 9'(ofs_s);
  assign ax_fire_s = bus.AXVALID & axready_q;
  assign m_fire_s  = bus.MREADY & mvalid_q;

  // Current command size and last flag, from registered state only.
  always_comb begin
    mbytes_s = 9'd0;
    mlast_s  = 1'b0;
    if (state_q == ST_SPLIT) begin
      mbytes_s = chunk_bytes(rem_q, space_s);
      mlast_s  = ({4'd0, mbytes_s} == rem_q);
    end else begin
      mbytes_s = 9'd0;
      mlast_s  = 1'b0;
    end
  end

  // Burst FSM with registered handshake and error outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      addr_q    <= 32'd0;
      rem_q     <= 13'd0;
      id_q      <= 4'd0;
      axready_q <= 1'b1;
      mvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ax_fire_s) begin
            if (total_s != 13'd0) begin
              addr_q    <= bus.AXADDR;
              rem_q     <= total_s;
              id_q      <= bus.AXID;
              state_q   <= ST_SPLIT;
              axready_q <= 1'b0;
              mvalid_q  <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_SPLIT: begin
          if (m_fire_s) begin
            addr_q <= addr_q + {23'd0, mbytes_s};
            rem_q  <= rem_q - {4'd0, mbytes_s};
            if (mlast_s) begin
              state_q   <= ST_IDLE;
              axready_q <= 1'b1;
              mvalid_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          axready_q <= 1'b1;
          mvalid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.AXREADY = axready_q;
  assign bus.MVALID  = mvalid_q;
  assign bus.MADDR   = addr_q;
  assign bus.MBYTES  = mbytes_s;
  assign bus.MID     = id_q;
  assign bus.MLAST   = mlast_s;
  assign bus.ERR     = err_q;

endmodule
